ext_int_sense: RTL and testbench
================================

Name: ext_int_sense

Overview:
- Generates the set/reset drive for the external-interrupt flag S-R latch (INT0/INT1/INT2 flags of the ATmega32A model); sits directly upstream of the latch and drives its s and r inputs.
- Synchronises and glitch-filters the raw pin, applies the ISC sense-control mode, and turns edge/level events into set requests.
- Turns interrupt acknowledge and software write-one-to-clear into clear requests.
- Resolves set/clear collisions so a new event is never lost.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on pin_in (legal range 2..4)
FILTER_CYCLES, 3, consecutive synchronised cycles a new level must persist before acceptance; 0 = filter bypassed
CNT_W, 3, filter counter width; must hold FILTER_CYCLES

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
pin_in  input  1  raw asynchronous external pin level
isc  input  2  sense control: 00 low level, 01 any edge, 10 falling, 11 rising
int_en  input  1  interrupt enable bit for this source (INTn in GICR)
ack  input  1  one-cycle interrupt-vector acknowledge from interrupt controller
flag_wr_clr  input  1  one-cycle software write of 1 to the flag bit
s_out  output  1  registered set request to latch s input
r_out  output  1  registered clear request to latch r input
pin_level  output  1  filtered pin level, for PIN register readback

Behaviour:
- Reset (rst_n low, asynchronous): sync flops = 1, filtered level = 1, previous level = 1, filter counter = 0, isc history = 00, s_out = 0, r_out = 0, pin_level = 1. Outputs stay 0 while reset is held. No spurious edge on reset release, because previous = filtered.
- Synchroniser: SYNC_STAGES flops; sync_out = last stage.
- Glitch filter:
  - Counter increments each cycle sync_out != filtered. It clears to 0 on any cycle sync_out == filtered.
  - When the counter reaches FILTER_CYCLES-1 and sync_out still differs, filtered takes sync_out at that edge and the counter clears.
  - A level that differs for fewer than FILTER_CYCLES consecutive cycles is discarded.
  - FILTER_CYCLES = 0: filtered = sync_out, registered one cycle.
- Edge detect:
  - fall = prev & ~filtered; rise = ~prev & filtered.
  - prev <= filtered every cycle.
- Set condition (combinational, registered into s_out):
  - isc 00: filtered == 0 AND int_en. s_out is a level and stays high every cycle the pin is low.
  - isc 01: fall | rise. isc 10: fall. isc 11: rise.
  - Edge modes are independent of int_en; the flag sets even when the interrupt is disabled.
  - Edge-mode s_out is exactly one cycle wide.
- Mode change: on any cycle where isc differs from its registered copy, the set condition is forced 0 for that cycle. No event is generated by the mode switch itself.
- Clear condition: ack | flag_wr_clr, registered into r_out; one cycle per request cycle.
- Collision:
  - If set and clear conditions are true in the same cycle, s_out = 1 and r_out = 0.
  - Set wins, so the flag stays pending for the new event.
  - The latch treats 11 as reset, so s_out = r_out = 1 must never be produced.
- Latency: pin_in change sampled at edge 0 → s_out high after edge SYNC_STAGES + FILTER_CYCLES + 1 (defaults: edge 6).
- Clear latency: ack at edge 0 → r_out high after edge 1, low after edge 2.
- Reset mid-operation: a partially counted filter or a pending s_out/r_out is discarded. The counter restarts from 0 after release.

Decomposition:
- Shared package ext_int_pkg:
  - ISC encodings: ISC_LOW_LEVEL = 2'b00, ISC_ANY_EDGE = 2'b01, ISC_FALLING = 2'b10, ISC_RISING = 2'b11.
  - Pin idle level constant PIN_IDLE = 1'b1.
- One sub-module: sync_chain (parameterised SYNC_STAGES, reset value PIN_IDLE). It is reused by other pin-input blocks.
- Filter, edge detect and set/clear arbitration stay in ext_int_sense.

Test Plan:
- Falling edge, defaults, isc=10: pin 1→0 sampled at edge 0 → s_out high for exactly one cycle after edge 6, r_out stays 0; then pin 0→1 → no s_out.
- Glitch rejection: pin low for 2 synchronised cycles, isc=01 → s_out never asserts, pin_level stays 1. A 3-cycle low pulse → two s_out pulses (fall, rise).
- Low-level mode, isc=00: int_en=1 with pin held low 10 cycles → s_out high continuously from edge 6. Same stimulus with int_en=0 → s_out stays 0.
- Collision: ack asserted in the same cycle the rising-edge set condition fires (isc=11) → s_out=1 and r_out=0 that cycle. ack alone one cycle later → r_out=1 for one cycle.
- Mode switch: pin held low, isc changed 11→10 → no s_out generated. flag_wr_clr pulse → r_out pulse after 1 edge.
- Reset mid-filter: pin low for 2 cycles, then rst_n asserted low for 1 cycle and released with pin still low → s_out=r_out=0 during reset. Falling-edge event occurs only a full latency (6 edges) after release.

Source files
------------

// File: rtl/ext_int_pkg.sv
// Shared definitions for the external-interrupt pin front end.
package ext_int_pkg;

  // Sense-control encodings (ISCn1:ISCn0)
  localparam logic [1:0] ISC_LOW_LEVEL = 2'b00;
  localparam logic [1:0] ISC_ANY_EDGE  = 2'b01;
  localparam logic [1:0] ISC_FALLING   = 2'b10;
  localparam logic [1:0] ISC_RISING    = 2'b11;

  // Level an undriven pin rests at; every pin-side flop resets here.
  localparam logic PIN_IDLE = 1'b1;

  // Raw set condition for one sense mode, before the mode-change guard.
  // Only low-level mode is gated by the enable; edge modes latch the flag regardless.
  function automatic logic sense_set(input logic [1:0] mode,
                                     input logic       fall,
                                     input logic       rise,
                                     input logic       level,
                                     input logic       enable);
    logic hit;
    hit = 1'b0;
    case (mode)
      ISC_LOW_LEVEL: hit = ~level & enable;
      ISC_ANY_EDGE:  hit = fall | rise;
      ISC_FALLING:   hit = fall;
      ISC_RISING:    hit = rise;
      default:       hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
module sync_chain
  import ext_int_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = PIN_IDLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stage_q;

  // Shift the raw input through the chain; stage 0 is the metastability catcher.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/ext_int_sense.sv
// Set/clear drive generation for one external-interrupt flag latch:
// synchronise, glitch-filter, sense, and arbitrate set against clear.
module ext_int_sense
  import ext_int_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 3,
  parameter int unsigned CNT_W         = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pin_in,
  input  logic [1:0] isc,
  input  logic       int_en,
  input  logic       ack,
  input  logic       flag_wr_clr,
  output logic       s_out,
  output logic       r_out,
  output logic       pin_level
);

  // Counter value on which a still-differing level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((FILTER_CYCLES == 0) ? 0 : FILTER_CYCLES - 1);

  logic             sync_out;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_q;
  logic [1:0]       isc_q;
  logic             s_q, r_q;
  logic             fall, rise;
  logic             set_req, clr_req;

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (PIN_IDLE)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pin_in),
    .q     (sync_out)
  );

  // Glitch filter: accept a new level only after it persists FILTER_CYCLES samples.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (FILTER_CYCLES == 0) begin
      filt_d = sync_out;
    end else if (sync_out != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_out;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign fall = prev_q & ~filt_q;
  assign rise = ~prev_q & filt_q;

  // Sense and arbitration; a mode switch suppresses the set for that cycle so
  // reconfiguring cannot itself post an event. Set beats clear so a fresh event
  // survives, and the latch never sees s=r=1.
  always_comb begin
    set_req = 1'b0;
    if (isc == isc_q) begin
      set_req = sense_set(isc, fall, rise, filt_q, int_en);
    end
    clr_req = (ack | flag_wr_clr) & ~set_req;
  end

  // Pin-side state: filtered level, previous level and filter count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= PIN_IDLE;
      prev_q <= PIN_IDLE;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      prev_q <= filt_q;
      cnt_q  <= cnt_d;
    end
  end

  // Mode history and registered latch drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isc_q <= ISC_LOW_LEVEL;
      s_q   <= 1'b0;
      r_q   <= 1'b0;
    end else begin
      isc_q <= isc;
      s_q   <= set_req;
      r_q   <= clr_req;
    end
  end

  assign s_out     = s_q;
  assign r_out     = r_q;
  assign pin_level = filt_q;

endmodule

// File: tb/tb_ext_int_sense.sv
// Directed plus randomized bench for ext_int_sense with a cycle-level reference model.
module tb_ext_int_sense;

  localparam int SYNC = 2;
  localparam int FILT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pin_in = 1'b1;
  logic [1:0] isc = 2'b00;
  logic       int_en = 1'b0;
  logic       ack = 1'b0;
  logic       flag_wr_clr = 1'b0;
  logic       s_out, r_out, pin_level;

  int checks = 0;
  int failures = 0;

  ext_int_sense #(
    .SYNC_STAGES   (SYNC),
    .FILTER_CYCLES (FILT),
    .CNT_W         (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pin_in      (pin_in),
    .isc         (isc),
    .int_en      (int_en),
    .ack         (ack),
    .flag_wr_clr (flag_wr_clr),
    .s_out       (s_out),
    .r_out       (r_out),
    .pin_level   (pin_level)
  );

  always #5 clk = ~clk;

  // Reference model: pin sample history, accepted level, run length of
  // disagreeing samples, and the outputs expected after each edge.
  bit         m_hist[SYNC];
  bit         m_level, m_prev, m_s, m_r;
  int         m_run;
  logic [1:0] m_isc;

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b1;
    m_level = 1'b1;
    m_prev  = 1'b1;
    m_run   = 0;
    m_s     = 1'b0;
    m_r     = 1'b0;
    m_isc   = 2'b00;
  endtask

  task automatic model_edge();
    bit seen, went_low, went_high, want_set, want_clr, new_level;
    if (!rst_n) begin
      model_reset();
    end else begin
      seen      = m_hist[SYNC-1];
      went_low  = m_prev && !m_level;
      went_high = !m_prev && m_level;
      if (isc == 2'd0)      want_set = !m_level && int_en;
      else if (isc == 2'd1) want_set = went_low || went_high;
      else if (isc == 2'd2) want_set = went_low;
      else                  want_set = went_high;
      if (isc != m_isc) want_set = 1'b0;
      want_clr = ack || flag_wr_clr;
      m_s = want_set;
      m_r = want_clr && !want_set;
      new_level = m_level;
      if (seen != m_level) begin
        m_run++;
        if (m_run >= FILT) begin
          new_level = seen;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_prev  = m_level;
      m_level = new_level;
      for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = pin_in;
      m_isc = isc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int cnt;
  int low_seen;

  initial begin
    model_reset();
    // Reset state
    ticks(3);
    check("reset_s", s_out, 0);
    check("reset_r", r_out, 0);
    check("reset_level", pin_level, 1);
    isc = 2'b10;
    rst_n = 1'b1;
    ticks(10);
    check("idle_s", s_out, 0);

    // Falling edge, isc=10: one-cycle pulse after edge 6
    pin_in = 1'b0;
    ticks(5);
    check("fall_early", s_out, 0);
    tick();
    check("fall_s", s_out, 1);
    check("fall_r", r_out, 0);
    tick();
    check("fall_width", s_out, 0);
    check("fall_level", pin_level, 0);
    pin_in = 1'b1;
    cnt = 0;
    repeat (12) begin tick(); cnt += int'(s_out); end
    check("rise_ignored", cnt, 0);
    check("rise_level", pin_level, 1);

    // Glitch rejection, isc=01
    isc = 2'b01;
    ticks(3);
    pin_in = 1'b0;
    ticks(2);
    pin_in = 1'b1;
    cnt = 0;
    low_seen = 0;
    repeat (12) begin
      tick();
      cnt += int'(s_out);
      if (!pin_level) low_seen = 1;
    end
    check("glitch_s", cnt, 0);
    check("glitch_level", low_seen, 0);
    pin_in = 1'b0;
    ticks(3);
    pin_in = 1'b1;
    cnt = 0;
    repeat (15) begin tick(); cnt += int'(s_out); end
    check("pulse3_events", cnt, 2);

    // Low-level mode, enabled then disabled
    isc = 2'b00;
    int_en = 1'b1;
    ticks(3);
    pin_in = 1'b0;
    ticks(5);
    check("low_early", s_out, 0);
    cnt = 0;
    repeat (10) begin tick(); cnt += int'(s_out); end
    check("low_held", cnt, 10);
    pin_in = 1'b1;
    ticks(10);
    check("low_released", s_out, 0);
    int_en = 1'b0;
    pin_in = 1'b0;
    cnt = 0;
    repeat (15) begin tick(); cnt += int'(s_out); end
    check("low_disabled", cnt, 0);
    pin_in = 1'b1;
    ticks(10);

    // Collision: ack in the same cycle the rising set fires
    isc = 2'b11;
    ticks(3);
    pin_in = 1'b0;
    ticks(10);
    pin_in = 1'b1;
    ticks(5);
    check("coll_early", s_out, 0);
    ack = 1'b1;
    tick();
    check("coll_s", s_out, 1);
    check("coll_r", r_out, 0);
    tick();
    check("ack_s", s_out, 0);
    check("ack_r", r_out, 1);
    ack = 1'b0;
    tick();
    check("ack_done", r_out, 0);

    // Mode switch 11->10 in the cycle a fall is visible: no event
    pin_in = 1'b0;
    ticks(5);
    isc = 2'b10;
    tick();
    check("mode_sw_s", s_out, 0);
    cnt = 0;
    repeat (8) begin tick(); cnt += int'(s_out); end
    check("mode_sw_after", cnt, 0);
    flag_wr_clr = 1'b1;
    tick();
    check("wrclr_r", r_out, 1);
    check("wrclr_s", s_out, 0);
    flag_wr_clr = 1'b0;
    tick();
    check("wrclr_done", r_out, 0);

    // Reset mid-filter discards the partial count
    pin_in = 1'b1;
    ticks(10);
    pin_in = 1'b0;
    ticks(3);
    rst_n = 1'b0;
    ack = 1'b1;
    #1;
    check("midrst_s", s_out, 0);
    check("midrst_r", r_out, 0);
    check("midrst_level", pin_level, 1);
    tick();
    check("midrst_r2", r_out, 0);
    rst_n = 1'b1;
    ack = 1'b0;
    ticks(5);
    check("postrst_early", s_out, 0);
    tick();
    check("postrst_fall", s_out, 1);
    ticks(5);

    // Randomized run against the reference model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) pin_in = ~pin_in;
      if ($urandom_range(0, 39) == 0) isc = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) int_en = ~int_en;
      ack = ($urandom_range(0, 9) == 0);
      flag_wr_clr = ($urandom_range(0, 11) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
      check("rnd_s", s_out, m_s);
      check("rnd_r", r_out, m_r);
      check("rnd_level", pin_level, m_level);
      check("rnd_never_both", s_out & r_out, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
